// File: rtl/ddr2_cmd_arbiter_if.sv
// AXI AW/AR request channels and the command channel toward the bank FSM.
// master = request/consumer side (AXI master + bank FSM), slave = the arbiter.
interface ddr2_cmd_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic [7:0]            axi_awlen;
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [7:0]            axi_arlen;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;

    modport master (
        output axi_awaddr, axi_awlen, axi_awvalid,
        input  axi_awready,
        output axi_araddr, axi_arlen, axi_arvalid,
        input  axi_arready,
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready
    );

    modport slave (
        input  axi_awaddr, axi_awlen, axi_awvalid,
        output axi_awready,
        input  axi_araddr, axi_arlen, axi_arvalid,
        output axi_arready,
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready
    );
endinterface

// File: rtl/ddr2_cmd_arbiter.sv
// Round-robin AW/AR arbiter feeding a small command FIFO; command issue is
// held off while any refresh is owed to the refresh controller.
module ddr2_cmd_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int MAX_REF_DEBT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ddr2_cmd_arbiter_if.slave        bus,
    input  logic                     refresh_req,
    input  logic                     refresh_ack,
    output logic                     refresh_pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(MAX_REF_DEBT) + 1;
    localparam int EW = 1 + 8 + ADDR_WIDTH;

    // Handshake rule shared by every channel here: a transfer happens on a
    // rising edge where valid and ready are both high; nothing else moves data.

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_grant_q, last_grant_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;

    logic          full, empty;
    logic          grant_write, grant_read;
    logic          push_w, push_r, push, pop;
    logic [EW-1:0] push_entry, head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // last_grant = 1 means write won last, so a tie now goes to read.
    assign grant_write = bus.axi_awvalid && (!bus.axi_arvalid || !last_grant_q);
    assign grant_read  = bus.axi_arvalid && (!bus.axi_awvalid ||  last_grant_q);

    assign bus.axi_awready = grant_write && !full;
    assign bus.axi_arready = grant_read  && !full;

    assign push_w = bus.axi_awvalid && bus.axi_awready;
    assign push_r = bus.axi_arvalid && bus.axi_arready;
    assign push   = push_w || push_r;
    assign push_entry = push_w ? {1'b1, bus.axi_awlen, bus.axi_awaddr}
                               : {1'b0, bus.axi_arlen, bus.axi_araddr};

    assign refresh_pending = (ref_cnt_q != '0);
    assign head            = mem_q[rd_ptr_q];
    assign bus.cmd_valid   = !empty && !refresh_pending;
    assign bus.cmd_write   = head[EW-1];
    assign bus.cmd_len     = head[EW-2 -: 8];
    assign bus.cmd_addr    = head[ADDR_WIDTH-1:0];
    assign pop             = bus.cmd_valid && bus.cmd_ready;
    assign fifo_count      = count_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        ref_cnt_d    = ref_cnt_q;

        if (push) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            last_grant_d = push_w;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (refresh_req && !refresh_ack && ref_cnt_q != RW'(MAX_REF_DEBT)) begin
            ref_cnt_d = ref_cnt_q + 1'b1;
        end else if (refresh_ack && !refresh_req && ref_cnt_q != '0) begin
            ref_cnt_d = ref_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b0;
            ref_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            ref_cnt_q    <= ref_cnt_d;
        end
    end

    // Storage carries no reset; stale entries are never visible because
    // cmd_valid depends on the cleared count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end
endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Directed + random bench for ddr2_cmd_arbiter with a reference model of
// arbitration, FIFO order and refresh debt.
module tb_ddr2_cmd_arbiter;
    localparam int AW      = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_REF = 8;
    localparam int EW      = 1 + 8 + AW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       refresh_req = 1'b0;
    logic       refresh_ack = 1'b0;
    logic       refresh_pending;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];
    logic          m_last;
    int            m_ref;

    always #5 clk = ~clk;

    ddr2_cmd_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    ddr2_cmd_arbiter #(
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .MAX_REF_DEBT(MAX_REF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .refresh_req    (refresh_req),
        .refresh_ack    (refresh_ack),
        .refresh_pending(refresh_pending),
        .fifo_count     (fifo_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.axi_awvalid = 1'b0;
        bus.axi_awaddr  = '0;
        bus.axi_awlen   = '0;
        bus.axi_arvalid = 1'b0;
        bus.axi_araddr  = '0;
        bus.axi_arlen   = '0;
        bus.cmd_ready   = 1'b0;
        refresh_req     = 1'b0;
        refresh_ack     = 1'b0;
    endtask

    // One clock: drive at negedge, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic cycle(input logic awv, input logic [AW-1:0] awa, input logic [7:0] awl,
                         input logic arv, input logic [AW-1:0] ara, input logic [7:0] arl,
                         input logic rdy, input logic rq, input logic ak);
        logic          full, gw, gr, ew, er, ecv;
        logic [EW-1:0] head;
        @(negedge clk);
        bus.axi_awvalid = awv;
        bus.axi_awaddr  = awa;
        bus.axi_awlen   = awl;
        bus.axi_arvalid = arv;
        bus.axi_araddr  = ara;
        bus.axi_arlen   = arl;
        bus.cmd_ready   = rdy;
        refresh_req     = rq;
        refresh_ack     = ak;
        #1;
        full = (exp_q.size() == DEPTH);
        gw   = awv && (!arv || !m_last);
        gr   = arv && (!awv || m_last);
        ew   = gw && !full;
        er   = gr && !full;
        ecv  = (exp_q.size() != 0) && (m_ref == 0);
        chk("awready", bus.axi_awready, ew);
        chk("arready", bus.axi_arready, er);
        chk("both_ready", bus.axi_awready && bus.axi_arready, 1'b0);
        chk("cmd_valid", bus.cmd_valid, ecv);
        chk("refresh_pending", refresh_pending, m_ref != 0);
        chk("fifo_count", fifo_count, exp_q.size());
        if (ecv) begin
            head = exp_q[0];
            chk("cmd_write", bus.cmd_write, head[EW-1]);
            chk("cmd_len", bus.cmd_len, head[EW-2 -: 8]);
            chk("cmd_addr", bus.cmd_addr, head[AW-1:0]);
        end
        @(posedge clk);
        if (ecv && rdy) void'(exp_q.pop_front());
        if (ew) begin
            exp_q.push_back({1'b1, awl, awa});
            m_last = 1'b1;
        end else if (er) begin
            exp_q.push_back({1'b0, arl, ara});
            m_last = 1'b0;
        end
        if (rq && !ak && m_ref < MAX_REF) m_ref++;
        else if (ak && !rq && m_ref > 0) m_ref--;
    endtask

    task automatic aw(input logic [AW-1:0] a, input logic [7:0] l, input logic rdy);
        cycle(1'b1, a, l, 1'b0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic ar(input logic [AW-1:0] a, input logic [7:0] l, input logic rdy);
        cycle(1'b0, '0, '0, 1'b1, a, l, rdy, 1'b0, 1'b0);
    endtask

    task automatic both(input logic [AW-1:0] wa, input logic [AW-1:0] ra, input logic rdy);
        cycle(1'b1, wa, 8'h0f, 1'b1, ra, 8'h07, rdy, 1'b0, 1'b0);
    endtask

    task automatic refc(input logic rq, input logic ak, input logic rdy);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, rdy, rq, ak);
    endtask

    task automatic reset_checks();
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_cmd_valid", bus.cmd_valid, 1'b0);
        chk("rst_refresh_pending", refresh_pending, 1'b0);
        chk("rst_awready", bus.axi_awready, 1'b0);
        chk("rst_arready", bus.axi_arready, 1'b0);
    endtask

    initial begin
        m_last = 1'b0;
        m_ref  = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, then consume it.
        aw(32'h0000_1000, 8'd3, 1'b0);
        refc(1'b0, 1'b0, 1'b0);
        refc(1'b0, 1'b0, 1'b1);

        // Ties alternate; cmd_ready held high.
        for (int i = 0; i < 4; i++) both(32'h2000 + i * 16, 32'h3000 + i * 16, 1'b1);
        repeat (3) refc(1'b0, 1'b0, 1'b1);

        // Fill to DEPTH, 5th read stalls until the first pop.
        for (int i = 0; i < 5; i++) ar(32'h4000 + i * 64, 8'(i), 1'b0);
        ar(32'h4000 + 4 * 64, 8'd4, 1'b1);
        ar(32'h4000 + 4 * 64, 8'd4, 1'b1);
        repeat (5) refc(1'b0, 1'b0, 1'b1);

        // Refresh gating with AW still accepted.
        aw(32'h5000, 8'd1, 1'b0);
        aw(32'h5100, 8'd2, 1'b0);
        cycle(1'b1, 32'h5200, 8'd3, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        aw(32'h5300, 8'd4, 1'b1);
        refc(1'b0, 1'b1, 1'b1);
        repeat (5) refc(1'b0, 1'b0, 1'b1);

        // Debt saturation and same-cycle req/ack.
        repeat (10) refc(1'b1, 1'b0, 1'b0);
        repeat (7) refc(1'b0, 1'b1, 1'b0);
        refc(1'b0, 1'b0, 1'b0);
        refc(1'b0, 1'b1, 1'b0);
        refc(1'b0, 1'b0, 1'b0);
        refc(1'b1, 1'b0, 1'b0);
        refc(1'b1, 1'b1, 1'b0);
        refc(1'b0, 1'b0, 1'b0);
        refc(1'b0, 1'b1, 1'b0);
        refc(1'b0, 1'b0, 1'b0);

        // Reset mid-operation: 3 entries queued, two refreshes owed.
        aw(32'h6000, 8'd1, 1'b0);
        ar(32'h6100, 8'd2, 1'b0);
        aw(32'h6200, 8'd3, 1'b0);
        refc(1'b1, 1'b0, 1'b0);
        refc(1'b1, 1'b0, 1'b0);
        refc(1'b0, 1'b0, 1'b0);
        #2;
        drive_idle();
        rst_n = 1'b0;
        #1;
        reset_checks();
        exp_q.delete();
        m_last = 1'b0;
        m_ref  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        both(32'h7000, 32'h7100, 1'b0);
        both(32'h7200, 32'h7300, 1'b0);
        repeat (3) refc(1'b0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end
        repeat (MAX_REF) refc(1'b0, 1'b1, 1'b1);
        repeat (DEPTH + 1) refc(1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr2_cmd_arbiter.md
# ddr2_cmd_arbiter

Front-end command stage of the DDR2 controller. It accepts AXI4 write-address (AW) and read-address (AR) requests, arbitrates between them round-robin, and buffers accepted requests in a small command FIFO. It presents one command at a time to the address decoder / bank FSM over a valid/ready handshake. It also gates command issue while refresh requests from the refresh controller are outstanding.

## Interface
- ADDR_WIDTH, 32, AXI/command address width
- DEPTH, 4, command FIFO entries; power of two, >= 2
- MAX_REF_DEBT, 8, maximum outstanding (postponed) refreshes tracked
- clk  input  1  controller clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- axi_awaddr  input  ADDR_WIDTH  write burst start address
- axi_awlen  input  8  write burst length minus one
- axi_awvalid  input  1  AW request valid
- axi_awready  output  1  AW accepted this cycle when high with awvalid
- axi_araddr  input  ADDR_WIDTH  read burst start address
- axi_arlen  input  8  read burst length minus one
- axi_arvalid  input  1  AR request valid
- axi_arready  output  1  AR accepted this cycle when high with arvalid
- cmd_valid  output  1  head command valid toward bank FSM
- cmd_ready  input  1  bank FSM takes head command
- cmd_write  output  1  1 = write, 0 = read
- cmd_addr  output  ADDR_WIDTH  start address, passed unmodified
- cmd_len  output  8  burst length minus one, passed unmodified
- refresh_req  input  1  one-cycle pulse per tREFI from the refresh controller
- refresh_ack  input  1  one-cycle pulse when the bank FSM completes a REFRESH
- refresh_pending  output  1  outstanding refresh count != 0
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO entry = {write, len[7:0], addr}. Storage is registered; head is read combinationally from the read pointer. Pointers wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
- Arbitration register last_grant: 0 = read, 1 = write. Reset value 0, so the first tie goes to write.
- Grant each cycle: only one valid high -> that side; both high -> the side != last_grant; neither -> no grant.
- axi_awready = grant_write && !full; axi_arready = grant_read && !full. At most one ready is high per cycle. Ready is never high without its valid.
- On an accepted handshake: push the entry, and set last_grant to the accepted side. last_grant is unchanged in cycles with no acceptance.
- cmd_valid = !empty && !refresh_pending. Pop on cmd_valid && cmd_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, no push occurs even if a pop happens in the same cycle (ready is derived from the registered count; no bypass).
- Refresh debt counter ref_cnt, width $clog2(MAX_REF_DEBT)+1:
  - req only: +1, saturating at MAX_REF_DEBT.
  - ack only: -1, no underflow at 0.
  - req and ack in the same cycle: unchanged.
- While ref_cnt != 0: the FIFO keeps accepting AXI requests, but no command issues. A command already presented is withdrawn (cmd_valid drops), which the bank FSM tolerates because refresh is exclusive.
- Reset, asynchronous on rst_n low:
  - Pointers, count, last_grant and ref_cnt are cleared.
  - cmd_valid=0, refresh_pending=0, fifo_count=0, axi_awready=0 and axi_arready=0 (with valids low).
  - FIFO contents are not cleared and are don't-care. An in-flight command is lost.

## Timing
- AXI-to-command latency is 1 cycle: a handshake at edge N gives cmd_valid=1 after edge N with the new entry, if the FIFO was empty and no refresh is pending.
- Ready outputs are combinational from valids and registered state.
- cmd_* outputs are combinational from registered state only; there is no input-to-output path on the command side.
- Throughput: 1 accepted request per cycle and 1 issued command per cycle, sustained when count is between 1 and DEPTH-1.
- refresh_req at edge N blocks cmd_valid from after edge N.
- The ack at edge M that brings ref_cnt to 0 re-enables cmd_valid after edge M.

## Test plan
- **Single write:** awvalid with addr 0x0000_1000, len 3 -> awready=1 the same cycle. Next cycle: cmd_valid=1, cmd_write=1, cmd_addr=0x1000, cmd_len=3, fifo_count=1.
- **Tie and alternation:** awvalid and arvalid held high, cmd_ready=1 -> acceptance order W, R, W, R. Never both readies high.
- **Full:** cmd_ready=0 and 5 reads offered with DEPTH=4 -> 4 accepted, arready=0 on the 5th, fifo_count=4. Raising cmd_ready pops in FIFO order, and the 5th is accepted the cycle after the first pop.
- **Refresh gating:** 2 commands queued, refresh_req pulse -> cmd_valid=0, refresh_pending=1 while AW is still accepted. refresh_ack -> cmd_valid returns the next cycle.
- **Refresh debt:** 10 req pulses with no ack -> ref_cnt saturates at 8. 8 acks clear refresh_pending. A req and ack in the same cycle leave the count unchanged.
- **Reset mid-operation:** rst_n low with 3 entries queued and ref_cnt=2 -> immediately fifo_count=0, cmd_valid=0, refresh_pending=0. After release, the first tie grants write.
